// File: rtl/text_console_pkg.sv
// Shared constants and types for the UART text console: ASCII controls,
// default grid size, FSM states and cursor-step operations.
package text_console_pkg;
   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] LF    = 8'h0A;
   localparam logic [7:0] BS    = 8'h08;
   localparam logic [7:0] DEL   = 8'h7F;
   localparam logic [7:0] FF    = 8'h0C;
   localparam logic [7:0] SPACE = 8'h20;

   localparam int DEF_COLS = 32;
   localparam int DEF_ROWS = 4;

   typedef enum logic {CLEAR, IDLE} state_t;

   typedef enum logic [1:0] {OP_NONE, OP_ADV, OP_NL, OP_BS} op_t;
endpackage

// File: rtl/uart_text_writer_cursor_step.sv
// Combinational next-cursor for advance, newline and backspace on a
// COLS x ROWS grid; all arithmetic wraps at the field width.
module cursor_step
   import text_console_pkg::*;
#(
   parameter int COLS = DEF_COLS,
   parameter int ROWS = DEF_ROWS,
   localparam int CW = $clog2(COLS),
   localparam int RW = $clog2(ROWS)
) (
   input  logic [RW-1:0] row,
   input  logic [CW-1:0] col,
   input  op_t           op,
   output logic [RW-1:0] next_row,
   output logic [CW-1:0] next_col,
   output logic          moved
);

   always_comb begin
      next_row = row;
      next_col = col;
      moved    = 1'b1;
      case (op)
         OP_ADV: begin
            next_col = col + CW'(1);
            if (col == CW'(COLS - 1)) next_row = row + RW'(1);
         end
         OP_NL: begin
            next_col = '0;
            next_row = row + RW'(1);
         end
         OP_BS: begin
            if (col != '0) begin
               next_col = col - CW'(1);
            end else if (row != '0) begin
               next_row = row - RW'(1);
               next_col = CW'(COLS - 1);
            end else begin
               // Backspace at the origin is a no-op.
               moved = 1'b0;
            end
         end
         default: moved = 1'b0;
      endcase
   end

endmodule

// File: rtl/uart_text_writer.sv
// Turns received UART bytes into character-RAM writes: cursor console with
// wrap, CR/LF newline, backspace, form-feed clear and a power-on blank sweep.
module uart_text_writer
   import text_console_pkg::*;
#(
   parameter int         COLS  = DEF_COLS,
   parameter int         ROWS  = DEF_ROWS,
   parameter logic [7:0] BLANK = SPACE,
   localparam int CW = $clog2(COLS),
   localparam int RW = $clog2(ROWS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          rx_ready,
   input  logic          clear_req,
   output logic          wr_en,
   output logic [RW-1:0] wr_row,
   output logic [CW-1:0] wr_col,
   output logic [7:0]    wr_data,
   output logic [RW-1:0] cur_row,
   output logic [CW-1:0] cur_col,
   output logic          busy
);

   localparam int SW = CW + RW + 1;

   state_t        state, state_d;
   logic [SW-1:0] cnt;
   logic          last_cr;
   logic          sweep_last;
   logic          take;

   op_t           op;
   logic          is_print, set_cr, is_ff;
   logic [7:0]    byte_data;
   logic [RW-1:0] step_row;
   logic [CW-1:0] step_col;
   logic          step_moved;

   assign sweep_last = (cnt == SW'(COLS * ROWS - 1));
   // A byte coinciding with clear_req is discarded.
   assign take       = rx_valid && rx_ready && !clear_req;

   cursor_step #(.COLS(COLS), .ROWS(ROWS)) u_step (
      .row      (cur_row),
      .col      (cur_col),
      .op       (op),
      .next_row (step_row),
      .next_col (step_col),
      .moved    (step_moved)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= CLEAR;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      if (clear_req)                      state_d = CLEAR;
      else if (state == CLEAR && sweep_last) state_d = IDLE;
      else if (state == IDLE && is_ff)    state_d = CLEAR;
   end

   always_comb begin
      rx_ready = (state == IDLE);
      busy     = (state == CLEAR);
   end

   always_comb begin
      op        = OP_NONE;
      is_print  = 1'b0;
      set_cr    = 1'b0;
      is_ff     = 1'b0;
      byte_data = rx_data;
      if (take) begin
         if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
            op       = OP_ADV;
            is_print = 1'b1;
         end else begin
            case (rx_data)
               CR: begin
                  op     = OP_NL;
                  set_cr = 1'b1;
               end
               LF:      if (!last_cr) op = OP_NL;
               BS, DEL: begin
                  op        = OP_BS;
                  byte_data = BLANK;
               end
               FF:      is_ff = 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         cur_row <= '0;
         cur_col <= '0;
         last_cr <= 1'b0;
         wr_en   <= 1'b0;
         wr_row  <= '0;
         wr_col  <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= 1'b0;
         if (clear_req) begin
            cnt <= '0;
         end else if (state == CLEAR) begin
            wr_en   <= 1'b1;
            wr_row  <= cnt[CW +: RW];
            wr_col  <= cnt[CW-1:0];
            wr_data <= BLANK;
            cnt     <= cnt + SW'(1);
            if (sweep_last) begin
               cur_row <= '0;
               cur_col <= '0;
               last_cr <= 1'b0;
            end
         end else if (take) begin
            last_cr <= set_cr;
            cur_row <= step_row;
            cur_col <= step_col;
            if (is_ff) cnt <= '0;
            // Printables land at the old cursor, backspace blanks the new one.
            if (is_print) begin
               wr_en   <= 1'b1;
               wr_row  <= cur_row;
               wr_col  <= cur_col;
               wr_data <= byte_data;
            end else if (op == OP_BS && step_moved) begin
               wr_en   <= 1'b1;
               wr_row  <= step_row;
               wr_col  <= step_col;
               wr_data <= byte_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_text_writer.sv
// Directed bench for uart_text_writer at default 32x4 geometry.
module tb_uart_text_writer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       clear_req;
   logic       wr_en;
   logic [1:0] wr_row;
   logic [4:0] wr_col;
   logic [7:0] wr_data;
   logic [1:0] cur_row;
   logic [4:0] cur_col;
   logic       busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_text_writer #(.COLS(32), .ROWS(4), .BLANK(8'h20)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .clear_req (clear_req),
      .wr_en     (wr_en),
      .wr_row    (wr_row),
      .wr_col    (wr_col),
      .wr_data   (wr_data),
      .cur_row   (cur_row),
      .cur_col   (cur_col),
      .busy      (busy)
   );

   // Present one byte for one cycle; outputs of that edge are visible on return.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_many(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) send_byte(b);
   endtask

   // Observe a full 128-cell sweep starting at the next edge.
   task automatic collect_sweep(output int bad, output int ready_bad);
      bad = 0;
      ready_bad = 0;
      for (int i = 0; i < 128; i++) begin
         @(posedge clk);
         #1;
         if (!(wr_en === 1'b1 && wr_row === 2'(i / 32) && wr_col === 5'(i % 32)
               && wr_data === 8'h20)) bad++;
         if (i < 127 && (rx_ready !== 1'b0 || busy !== 1'b1)) ready_bad++;
         if (i == 127 && (rx_ready !== 1'b1 || busy !== 1'b0)) ready_bad++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; clear_req = 1'b0;
      #23;
      checks++;
      if ({wr_en, wr_row, wr_col, wr_data, cur_row, cur_col, rx_ready, busy}
          !== {1'b0, 2'd0, 5'd0, 8'h00, 2'd0, 5'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state got wr=%b r=%0d c=%0d d=%h cur=(%0d,%0d) rdy=%b busy=%b exp all zero, busy=1",
                  wr_en, wr_row, wr_col, wr_data, cur_row, cur_col, rx_ready, busy);
      end
   endtask

   task automatic test_power_on_clear;
      int bad, ready_bad;
      @(negedge clk);
      reset = 1'b0;
      collect_sweep(bad, ready_bad);
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL poweron_sweep bad_cells=%0d exp 0", bad);
      end
      checks++;
      if (ready_bad !== 0) begin
         errors++; $display("FAIL poweron_ready bad_cycles=%0d exp 0", ready_bad);
      end
      @(posedge clk); #1;
      checks++;
      if ({wr_en, rx_ready, cur_row, cur_col} !== {1'b0, 1'b1, 2'd0, 5'd0}) begin
         errors++;
         $display("FAIL poweron_end got wr=%b rdy=%b cur=(%0d,%0d) exp 0,1,(0,0)",
                  wr_en, rx_ready, cur_row, cur_col);
      end
   endtask

   task automatic test_wrap;
      send_many(8'h61, 63);
      checks++;
      if ({cur_row, cur_col} !== {2'd1, 5'd31}) begin
         errors++; $display("FAIL wrap_setup got (%0d,%0d) exp (1,31)", cur_row, cur_col);
      end
      send_byte(8'h41);
      checks++;
      if ({wr_en, wr_row, wr_col, wr_data, cur_row, cur_col}
          !== {1'b1, 2'd1, 5'd31, 8'h41, 2'd2, 5'd0}) begin
         errors++;
         $display("FAIL wrap_col got wr=%b (%0d,%0d,%h) cur=(%0d,%0d) exp 1 (1,31,41) cur=(2,0)",
                  wr_en, wr_row, wr_col, wr_data, cur_row, cur_col);
      end
      @(posedge clk); #1;
      checks++;
      if (wr_en !== 1'b0) begin
         errors++; $display("FAIL write_one_cycle got wr=%b exp 0", wr_en);
      end
      send_many(8'h62, 63);
      send_byte(8'h42);
      checks++;
      if ({wr_en, wr_row, wr_col, wr_data, cur_row, cur_col}
          !== {1'b1, 2'd3, 5'd31, 8'h42, 2'd0, 5'd0}) begin
         errors++;
         $display("FAIL wrap_row got wr=%b (%0d,%0d,%h) cur=(%0d,%0d) exp 1 (3,31,42) cur=(0,0)",
                  wr_en, wr_row, wr_col, wr_data, cur_row, cur_col);
      end
   endtask

   task automatic test_newline;
      send_byte(8'h58);
      checks++;
      if ({wr_en, wr_row, wr_col, wr_data} !== {1'b1, 2'd0, 5'd0, 8'h58}) begin
         errors++; $display("FAIL nl_x got wr=%b (%0d,%0d,%h) exp 1 (0,0,58)", wr_en, wr_row, wr_col, wr_data);
      end
      send_byte(8'h0D);
      checks++;
      if ({wr_en, cur_row, cur_col} !== {1'b0, 2'd1, 5'd0}) begin
         errors++; $display("FAIL nl_cr got wr=%b cur=(%0d,%0d) exp 0 (1,0)", wr_en, cur_row, cur_col);
      end
      send_byte(8'h0A);
      checks++;
      if ({wr_en, cur_row, cur_col} !== {1'b0, 2'd1, 5'd0}) begin
         errors++; $display("FAIL nl_crlf got wr=%b cur=(%0d,%0d) exp 0 (1,0)", wr_en, cur_row, cur_col);
      end
      send_byte(8'h59);
      checks++;
      if ({wr_en, wr_row, wr_col, wr_data, cur_row, cur_col}
          !== {1'b1, 2'd1, 5'd0, 8'h59, 2'd1, 5'd1}) begin
         errors++;
         $display("FAIL nl_y got wr=%b (%0d,%0d,%h) cur=(%0d,%0d) exp 1 (1,0,59) cur=(1,1)",
                  wr_en, wr_row, wr_col, wr_data, cur_row, cur_col);
      end
      send_many(8'h63, 4);
      send_byte(8'h0A);
      checks++;
      if ({wr_en, cur_row, cur_col} !== {1'b0, 2'd2, 5'd0}) begin
         errors++; $display("FAIL nl_lone_lf got wr=%b cur=(%0d,%0d) exp 0 (2,0)", wr_en, cur_row, cur_col);
      end
   endtask

   task automatic test_backspace;
      send_byte(8'h08);
      checks++;
      if ({wr_en, wr_row, wr_col, wr_data, cur_row, cur_col}
          !== {1'b1, 2'd1, 5'd31, 8'h20, 2'd1, 5'd31}) begin
         errors++;
         $display("FAIL bs_row got wr=%b (%0d,%0d,%h) cur=(%0d,%0d) exp 1 (1,31,20) cur=(1,31)",
                  wr_en, wr_row, wr_col, wr_data, cur_row, cur_col);
      end
      send_many(8'h0D, 3);
      send_byte(8'h7F);
      checks++;
      if ({wr_en, cur_row, cur_col} !== {1'b0, 2'd0, 5'd0}) begin
         errors++; $display("FAIL bs_origin got wr=%b cur=(%0d,%0d) exp 0 (0,0)", wr_en, cur_row, cur_col);
      end
      send_byte(8'h71);
      send_byte(8'h08);
      checks++;
      if ({wr_en, wr_row, wr_col, wr_data, cur_row, cur_col}
          !== {1'b1, 2'd0, 5'd0, 8'h20, 2'd0, 5'd0}) begin
         errors++;
         $display("FAIL bs_col got wr=%b (%0d,%0d,%h) cur=(%0d,%0d) exp 1 (0,0,20) cur=(0,0)",
                  wr_en, wr_row, wr_col, wr_data, cur_row, cur_col);
      end
      send_byte(8'h01);
      checks++;
      if ({wr_en, cur_row, cur_col} !== {1'b0, 2'd0, 5'd0}) begin
         errors++; $display("FAIL ignored_byte got wr=%b cur=(%0d,%0d) exp 0 (0,0)", wr_en, cur_row, cur_col);
      end
   endtask

   task automatic test_back_to_back;
      send_byte(8'h6D);
      checks++;
      if ({wr_en, wr_row, wr_col, wr_data, rx_ready} !== {1'b1, 2'd0, 5'd0, 8'h6D, 1'b1}) begin
         errors++; $display("FAIL b2b_first got wr=%b (%0d,%0d,%h) rdy=%b exp 1 (0,0,6d) 1",
                            wr_en, wr_row, wr_col, wr_data, rx_ready);
      end
      send_byte(8'h6E);
      checks++;
      if ({wr_en, wr_row, wr_col, wr_data, cur_col} !== {1'b1, 2'd0, 5'd1, 8'h6E, 5'd2}) begin
         errors++; $display("FAIL b2b_second got wr=%b (%0d,%0d,%h) col=%0d exp 1 (0,1,6e) col=2",
                            wr_en, wr_row, wr_col, wr_data, cur_col);
      end
   endtask

   task automatic test_clear_collision;
      int bad, ready_bad;
      send_byte(8'h0D);
      @(negedge clk);
      rx_data = 8'h5A; rx_valid = 1'b1; clear_req = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0; clear_req = 1'b0;
      checks++;
      if ({wr_en, busy, rx_ready} !== {1'b0, 1'b1, 1'b0}) begin
         errors++; $display("FAIL collide_drop got wr=%b busy=%b rdy=%b exp 0 1 0", wr_en, busy, rx_ready);
      end
      collect_sweep(bad, ready_bad);
      checks++;
      if (bad + ready_bad !== 0) begin
         errors++; $display("FAIL collide_sweep bad=%0d ready_bad=%0d exp 0", bad, ready_bad);
      end
      send_byte(8'h0A);
      checks++;
      if ({wr_en, cur_row, cur_col} !== {1'b0, 2'd1, 5'd0}) begin
         errors++; $display("FAIL collide_lastcr got wr=%b cur=(%0d,%0d) exp 0 (1,0)", wr_en, cur_row, cur_col);
      end
   endtask

   task automatic test_form_feed;
      int bad, ready_bad;
      send_byte(8'h0C);
      checks++;
      if ({wr_en, busy, rx_ready} !== {1'b0, 1'b1, 1'b0}) begin
         errors++; $display("FAIL ff_enter got wr=%b busy=%b rdy=%b exp 0 1 0", wr_en, busy, rx_ready);
      end
      repeat (10) @(posedge clk);
      @(negedge clk);
      clear_req = 1'b1;
      @(posedge clk); #1;
      clear_req = 1'b0;
      checks++;
      if ({wr_en, busy} !== {1'b0, 1'b1}) begin
         errors++; $display("FAIL ff_restart got wr=%b busy=%b exp 0 1", wr_en, busy);
      end
      collect_sweep(bad, ready_bad);
      checks++;
      if (bad + ready_bad !== 0 || {cur_row, cur_col} !== {2'd0, 5'd0}) begin
         errors++; $display("FAIL ff_sweep bad=%0d ready_bad=%0d cur=(%0d,%0d) exp 0 0 (0,0)",
                            bad, ready_bad, cur_row, cur_col);
      end
   endtask

   task automatic test_reset_mid_sweep;
      int bad, ready_bad;
      send_byte(8'h41);
      send_byte(8'h0C);
      repeat (41) @(posedge clk);
      #1;
      checks++;
      if ({wr_en, wr_row, wr_col} !== {1'b1, 2'd1, 5'd8}) begin
         errors++; $display("FAIL mid_cell40 got wr=%b (%0d,%0d) exp 1 (1,8)", wr_en, wr_row, wr_col);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({wr_en, wr_row, wr_col, wr_data, busy} !== {1'b0, 2'd0, 5'd0, 8'h00, 1'b1}) begin
         errors++; $display("FAIL async_reset got wr=%b (%0d,%0d,%h) busy=%b exp 0 (0,0,00) 1",
                            wr_en, wr_row, wr_col, wr_data, busy);
      end
      @(negedge clk);
      reset = 1'b0;
      collect_sweep(bad, ready_bad);
      checks++;
      if (bad + ready_bad !== 0) begin
         errors++; $display("FAIL reset_restart bad=%0d ready_bad=%0d exp 0", bad, ready_bad);
      end
   endtask

   initial begin
      test_reset();
      test_power_on_clear();
      test_wrap();
      test_newline();
      test_backspace();
      test_back_to_back();
      test_clear_collision();
      test_form_feed();
      test_reset_mid_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
